// File: rtl/id_fwd_stage.sv
// Registered MIPS decode stage (logic/immediate subset) with multi-source operand forwarding.
// Optional load-use stall logic is enabled by defining ID_LOAD_USE_STALL_EN.
module id_fwd_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned FWD_N  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               pc_i,
  input  logic [31:0]               inst_i,
  output logic [ADDR_W-1:0]         reg1_addr_o,
  output logic [ADDR_W-1:0]         reg2_addr_o,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [FWD_N-1:0]          fwd_wreg_i,
  input  logic [FWD_N*ADDR_W-1:0]   fwd_wd_i,
  input  logic [FWD_N*DATA_W-1:0]   fwd_wdata_i,
  input  logic [FWD_N-1:0]          fwd_load_i,
  input  logic                      flush_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               pc_o,
  output logic [7:0]                aluop_o,
  output logic [2:0]                alusel_o,
  output logic [ADDR_W-1:0]         wd_o,
  output logic                      wreg_o,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic                      stallreq_o,
  output logic [15:0]               stall_cycles_o
);

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpAndi    = 6'b001100;
  localparam logic [5:0] OpOri     = 6'b001101;
  localparam logic [5:0] OpXori    = 6'b001110;
  localparam logic [5:0] OpLui     = 6'b001111;
  localparam logic [5:0] FnAnd     = 6'b100100;
  localparam logic [5:0] FnOr      = 6'b100101;
  localparam logic [5:0] FnXor     = 6'b100110;
  localparam logic [5:0] FnNor     = 6'b100111;

  localparam logic [7:0] AluAnd = 8'h24;
  localparam logic [7:0] AluOr  = 8'h25;
  localparam logic [7:0] AluXor = 8'h26;
  localparam logic [7:0] AluNor = 8'h27;
  localparam logic [2:0] SelLogic = 3'b001;

  typedef enum logic {StRun, StStall} state_e;

  logic [5:0]        opcode;
  logic [5:0]        func;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;

  assign opcode = inst_i[31:26];
  assign func   = inst_i[5:0];
  assign imm    = inst_i[15:0];
  assign rs     = ADDR_W'(inst_i[25:21]);
  assign rt     = ADDR_W'(inst_i[20:16]);
  assign rd     = ADDR_W'(inst_i[15:11]);

  // Decode
  logic [7:0]        dec_aluop;
  logic [2:0]        dec_alusel;
  logic [ADDR_W-1:0] dec_wd;
  logic              dec_wreg;
  logic              dec_rd1_en;
  logic              dec_rd2_en;
  logic [DATA_W-1:0] dec_imm;

  always_comb begin
    dec_aluop  = 8'h00;
    dec_alusel = 3'b000;
    dec_wd     = '0;
    dec_wreg   = 1'b0;
    dec_rd1_en = 1'b0;
    dec_rd2_en = 1'b0;
    dec_imm    = '0;
    case (opcode)
      OpOri, OpAndi, OpXori: begin
        dec_aluop  = (opcode == OpOri)  ? AluOr  :
                     (opcode == OpAndi) ? AluAnd : AluXor;
        dec_alusel = SelLogic;
        dec_rd1_en = 1'b1;
        dec_imm    = DATA_W'(imm);
        dec_wd     = rt;
        dec_wreg   = 1'b1;
      end
      OpLui: begin
        dec_aluop  = AluOr;
        dec_alusel = SelLogic;
        dec_imm    = DATA_W'(imm) << (DATA_W - 16);
        dec_wd     = rt;
        dec_wreg   = 1'b1;
      end
      OpSpecial: begin
        case (func)
          FnOr, FnAnd, FnXor, FnNor: begin
            dec_aluop  = (func == FnOr)  ? AluOr  :
                         (func == FnAnd) ? AluAnd :
                         (func == FnXor) ? AluXor : AluNor;
            dec_alusel = SelLogic;
            dec_rd1_en = 1'b1;
            dec_rd2_en = 1'b1;
            dec_wd     = rd;
            dec_wreg   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Forwarding: scan from oldest to youngest so the lowest matching index wins.
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;
  logic              fwd1_load;
  logic              fwd2_load;

  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    fwd1_load = 1'b0;
    fwd2_load = 1'b0;
    for (int k = FWD_N - 1; k >= 0; k--) begin
      if (fwd_wreg_i[k] && (fwd_wd_i[k*ADDR_W +: ADDR_W] == rs)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = fwd_wdata_i[k*DATA_W +: DATA_W];
        fwd1_load = fwd_load_i[k];
      end
      if (fwd_wreg_i[k] && (fwd_wd_i[k*ADDR_W +: ADDR_W] == rt)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = fwd_wdata_i[k*DATA_W +: DATA_W];
        fwd2_load = fwd_load_i[k];
      end
    end
  end

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  always_comb begin
    op1 = '0;
    op2 = dec_imm;
    if (dec_rd1_en && (rs != '0)) begin
      op1 = fwd1_hit ? fwd1_data : reg1_data_i;
    end
    if (dec_rd2_en) begin
      op2 = (rt == '0) ? '0 : (fwd2_hit ? fwd2_data : reg2_data_i);
    end
  end

  logic hazard;

`ifdef ID_LOAD_USE_STALL_EN
  logic hz1;
  logic hz2;
  assign hz1    = dec_rd1_en && (rs != '0) && fwd1_hit && fwd1_load;
  assign hz2    = dec_rd2_en && (rt != '0) && fwd2_hit && fwd2_load;
  assign hazard = !rst && in_valid && (hz1 || hz2);
`else
  // Loads are treated as already resolved; their data is forwarded directly.
  assign hazard = 1'b0;
`endif

  // FSM: state register / next state / outputs
  state_e state_q;
  state_e state_d;
  logic   stall_cnt_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StRun;
    end else begin
      case (state_q)
        StRun:   if (hazard) state_d = StStall;
        StStall: if (!hazard) state_d = StRun;
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    stall_cnt_en = (state_q == StStall);
    stallreq_o   = hazard;
  end

`ifdef ID_LOAD_USE_STALL_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (stall_cnt_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  logic unused_stall;
  assign unused_stall   = ^{fwd1_load, fwd2_load, stall_cnt_en};
  assign stall_cycles_o = 16'd0;
`endif

  // Handshake and combinational regfile interface
  logic out_valid_q;
  logic accept;

  assign in_ready    = !rst && !hazard && !flush_i && (out_ready || !out_valid_q);
  assign accept      = in_valid && in_ready;
  assign reg1_addr_o = rst ? '0 : rs;
  assign reg2_addr_o = rst ? '0 : rt;
  assign reg1_read_o = !rst && dec_rd1_en;
  assign reg2_read_o = !rst && dec_rd2_en;

  // ID/EX output register
  logic [31:0]       pc_q;
  logic [7:0]        aluop_q;
  logic [2:0]        alusel_q;
  logic [ADDR_W-1:0] wd_q;
  logic              wreg_q;
  logic [DATA_W-1:0] reg1_q;
  logic [DATA_W-1:0] reg2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      aluop_q     <= '0;
      alusel_q    <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      reg1_q      <= '0;
      reg2_q      <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      pc_q        <= pc_i;
      aluop_q     <= dec_aluop;
      alusel_q    <= dec_alusel;
      wd_q        <= dec_wd;
      wreg_q      <= dec_wreg;
      reg1_q      <= op1;
      reg2_q      <= op2;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_o      = pc_q;
  assign aluop_o   = aluop_q;
  assign alusel_o  = alusel_q;
  assign wd_o      = wd_q;
  assign wreg_o    = wreg_q;
  assign reg1_o    = reg1_q;
  assign reg2_o    = reg2_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: vector table through a scoreboard plus load-use and hold/flush sequences.
// Covers both builds of ID_LOAD_USE_STALL_EN.
module tb_id_fwd_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [4:0]  reg1_addr_o;
  logic [4:0]  reg2_addr_o;
  logic        reg1_read_o;
  logic        reg2_read_o;
  logic [31:0] reg1_data_i;
  logic [31:0] reg2_data_i;
  logic [1:0]  fwd_wreg_i;
  logic [9:0]  fwd_wd_i;
  logic [63:0] fwd_wdata_i;
  logic [1:0]  fwd_load_i;
  logic        flush_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] reg1_o;
  logic [31:0] reg2_o;
  logic        stallreq_o;
  logic [15:0] stall_cycles_o;

  id_fwd_stage #(.DATA_W(32), .ADDR_W(5), .FWD_N(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
    .fwd_load_i(fwd_load_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_o(pc_o), .aluop_o(aluop_o), .alusel_o(alusel_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o),
    .stallreq_o(stallreq_o), .stall_cycles_o(stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [1:0]  fwreg;
    logic [9:0]  fwd;
    logic [63:0] fdata;
    logic [1:0]  fload;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        re1;
    logic        re2;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[12];
  vec_t v;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act !== expv) $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic vec_t mkv(logic [31:0] inst, logic [31:0] pc, logic [31:0] rd1,
                               logic [31:0] rd2, logic [1:0] fwreg, logic [9:0] fwd,
                               logic [63:0] fdata, logic [1:0] fload, logic [7:0] aluop,
                               logic [2:0] alusel, logic [4:0] wd, logic wreg,
                               logic [31:0] r1, logic [31:0] r2, logic re1, logic re2);
    vec_t t;
    t.inst = inst; t.pc = pc; t.rd1 = rd1; t.rd2 = rd2;
    t.fwreg = fwreg; t.fwd = fwd; t.fdata = fdata; t.fload = fload;
    t.aluop = aluop; t.alusel = alusel; t.wd = wd; t.wreg = wreg;
    t.r1 = r1; t.r2 = r2; t.re1 = re1; t.re2 = re2;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t t);
    pc_i = t.pc; inst_i = t.inst; reg1_data_i = t.rd1; reg2_data_i = t.rd2;
    fwd_wreg_i = t.fwreg; fwd_wd_i = t.fwd; fwd_wdata_i = t.fdata; fwd_load_i = t.fload;
  endtask

  task automatic push_exp(input vec_t t);
    exp_t e;
    e.pc = t.pc; e.aluop = t.aluop; e.alusel = t.alusel; e.wd = t.wd;
    e.wreg = t.wreg; e.r1 = t.r1; e.r2 = t.r2;
    exp_q.push_back(e);
  endtask

  // Drive one instruction, wait (bounded) for acceptance, record its expected result.
  task automatic issue(input vec_t t);
    logic [4:0] rs_f;
    rs_f = t.inst[25:21];
    drive(t);
    in_valid = 1'b1;
    #1;
    chk("reg1_read", reg1_read_o, t.re1);
    chk("reg2_read", reg2_read_o, t.re2);
    chk("reg1_addr", reg1_addr_o, rs_f);
    for (int c = 0; c < 20 && !in_ready; c++) step();
    chk("issue_ready", in_ready, 1);
    if (in_ready) begin
      push_exp(t);
      step();
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", out_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pc_o", pc_o, mon_e.pc);
        chk("aluop_o", aluop_o, mon_e.aluop);
        chk("alusel_o", alusel_o, mon_e.alusel);
        chk("wd_o", wd_o, mon_e.wd);
        chk("wreg_o", wreg_o, mon_e.wreg);
        chk("reg1_o", reg1_o, mon_e.r1);
        chk("reg2_o", reg2_o, mon_e.r2);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; flush_i = 1'b0; out_ready = 1'b1;
    pc_i = 32'h4; inst_i = itype(6'h0D, 5'd1, 5'd2, 16'h00FF);
    reg1_data_i = 32'h0; reg2_data_i = 32'h0;
    fwd_wreg_i = 2'b00; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_load_i = 2'b00;

    // Reset state and combinational outputs held low during reset
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_reg1_read", reg1_read_o, 0);
    chk("rst_reg1_addr", reg1_addr_o, 0);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_reg2_o", reg2_o, 0);
    chk("rst_stall_cycles", stall_cycles_o, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_out_valid", out_valid, 0);

    vecs[0]  = mkv(itype(6'h0D, 5'd1, 5'd2, 16'hF0F0), 32'h100, 32'hFFFF_FFFF, 32'h0,
                   2'b01, {5'd0, 5'd1}, {32'h0, 32'h0000_0F0F}, 2'b00,
                   8'h25, 3'b001, 5'd2, 1'b1, 32'h0F0F, 32'hF0F0, 1'b1, 1'b0);
    vecs[1]  = mkv(rtype(5'd1, 5'd1, 5'd3, 6'h25), 32'h104, 32'h0, 32'h0,
                   2'b11, {5'd1, 5'd1}, {32'h22, 32'h11}, 2'b00,
                   8'h25, 3'b001, 5'd3, 1'b1, 32'h11, 32'h11, 1'b1, 1'b1);
    vecs[2]  = mkv(rtype(5'd1, 5'd1, 5'd3, 6'h25), 32'h108, 32'h0, 32'h0,
                   2'b10, {5'd1, 5'd1}, {32'h22, 32'h11}, 2'b00,
                   8'h25, 3'b001, 5'd3, 1'b1, 32'h22, 32'h22, 1'b1, 1'b1);
    vecs[3]  = mkv(itype(6'h0C, 5'd6, 5'd5, 16'h8001), 32'h10C, 32'hAAAA_5555, 32'h0,
                   2'b00, {5'd0, 5'd0}, 64'h0, 2'b00,
                   8'h24, 3'b001, 5'd5, 1'b1, 32'hAAAA_5555, 32'h8001, 1'b1, 1'b0);
    vecs[4]  = mkv(itype(6'h0E, 5'd0, 5'd7, 16'h1234), 32'h110, 32'h77, 32'h0,
                   2'b01, {5'd0, 5'd0}, {32'h0, 32'hDEAD}, 2'b01,
                   8'h26, 3'b001, 5'd7, 1'b1, 32'h0, 32'h1234, 1'b1, 1'b0);
    vecs[5]  = mkv(itype(6'h0F, 5'd9, 5'd4, 16'h1234), 32'h114, 32'h9999, 32'h0,
                   2'b01, {5'd0, 5'd9}, {32'h0, 32'hBEEF}, 2'b00,
                   8'h25, 3'b001, 5'd4, 1'b1, 32'h0, 32'h1234_0000, 1'b0, 1'b0);
    vecs[6]  = mkv(rtype(5'd9, 5'd10, 5'd8, 6'h24), 32'h118, 32'hF0, 32'h1234,
                   2'b10, {5'd10, 5'd0}, {32'h0F0F_0000, 32'h0}, 2'b00,
                   8'h24, 3'b001, 5'd8, 1'b1, 32'hF0, 32'h0F0F_0000, 1'b1, 1'b1);
    vecs[7]  = mkv(rtype(5'd2, 5'd3, 5'd1, 6'h26), 32'h11C, 32'h22, 32'h33,
                   2'b00, {5'd3, 5'd3}, {32'hBAD1, 32'hBAD0}, 2'b00,
                   8'h26, 3'b001, 5'd1, 1'b1, 32'h22, 32'h33, 1'b1, 1'b1);
    vecs[8]  = mkv(rtype(5'd12, 5'd13, 5'd11, 6'h27), 32'h120, 32'h1, 32'h2,
                   2'b00, {5'd0, 5'd0}, 64'h0, 2'b00,
                   8'h27, 3'b001, 5'd11, 1'b1, 32'h1, 32'h2, 1'b1, 1'b1);
    vecs[9]  = mkv(32'h8C22_0004, 32'h124, 32'h5, 32'h6,
                   2'b01, {5'd0, 5'd1}, {32'h0, 32'h77}, 2'b00,
                   8'h00, 3'b000, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vecs[10] = mkv(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h128, 32'h5, 32'h6,
                   2'b00, {5'd0, 5'd0}, 64'h0, 2'b00,
                   8'h00, 3'b000, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vecs[11] = mkv(rtype(5'd0, 5'd5, 5'd6, 6'h25), 32'h12C, 32'h44, 32'h0,
                   2'b01, {5'd0, 5'd5}, {32'h0, 32'h5A}, 2'b00,
                   8'h25, 3'b001, 5'd6, 1'b1, 32'h0, 32'h5A, 1'b1, 1'b1);

    for (int i = 0; i < 12; i++) issue(vecs[i]);
    step();
    step();
    chk("sb_drained_vectors", exp_q.size(), 0);

    // Load-use on $1 from the youngest source
    v = mkv(itype(6'h0D, 5'd1, 5'd2, 16'h0001), 32'h200, 32'h0, 32'h0,
            2'b01, {5'd0, 5'd1}, {32'h0, 32'h99}, 2'b01,
            8'h25, 3'b001, 5'd2, 1'b1, 32'h0, 32'h1, 1'b1, 1'b0);
    drive(v);
    in_valid = 1'b1;
    #1;
`ifdef ID_LOAD_USE_STALL_EN
    chk("lu_stallreq_c1", stallreq_o, 1);
    chk("lu_in_ready_c1", in_ready, 0);
    step();
    chk("lu_stallreq_c2", stallreq_o, 1);
    chk("lu_in_ready_c2", in_ready, 0);
    step();
    fwd_wreg_i = 2'b10; fwd_wd_i = {5'd1, 5'd0};
    fwd_wdata_i = {32'h55, 32'h0}; fwd_load_i = 2'b00;
    #1;
    chk("lu_stallreq_clr", stallreq_o, 0);
    chk("lu_in_ready_clr", in_ready, 1);
    v.r1 = 32'h55;
    push_exp(v);
    step();
    in_valid = 1'b0;
    chk("lu_stall_cycles", stall_cycles_o, 2);
    step();
    chk("lu_stall_cycles_hold", stall_cycles_o, 2);
`else
    chk("lu_stallreq", stallreq_o, 0);
    chk("lu_in_ready", in_ready, 1);
    v.r1 = 32'h99;
    push_exp(v);
    step();
    in_valid = 1'b0;
    chk("lu_stall_cycles", stall_cycles_o, 0);
    step();
`endif
    step();
    chk("sb_drained_lu", exp_q.size(), 0);

    // Backpressure hold then flush
    out_ready = 1'b0;
    v = mkv(itype(6'h0F, 5'd0, 5'd4, 16'h1234), 32'h300, 32'h0, 32'h0,
            2'b00, {5'd0, 5'd0}, 64'h0, 2'b00,
            8'h25, 3'b001, 5'd4, 1'b1, 32'h0, 32'h1234_0000, 1'b0, 1'b0);
    drive(v);
    in_valid = 1'b1;
    #1;
    chk("hold_first_ready", in_ready, 1);
    push_exp(v);
    step();
    inst_i = itype(6'h0D, 5'd3, 5'd3, 16'h0003);
    pc_i = 32'h304;
    for (int c = 0; c < 3; c++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_reg2_o", reg2_o, 32'h1234_0000);
      chk("hold_pc_o", pc_o, 32'h300);
      chk("hold_in_ready", in_ready, 0);
      step();
    end
    flush_i = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    step();
    flush_i = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    out_ready = 1'b1;
    issue(vecs[0]);
    step();
    step();
    chk("sb_drained_final", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
